// File: rtl/quadrant_dispatch_if.sv
// Node-side packet bus and quadrant-link bus for quadrant_dispatch.
// The slave modport is the dispatch stage; the master modport is the node/link environment.
interface quadrant_dispatch_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_dst;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [1:0]        out_quad;
  logic [4:0]        out_dst;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        credit_ret;
  logic              credit_err;
  logic [7:0]        drop_cnt;

  modport master (
    output in_valid, in_dst, in_data, credit_ret,
    input  in_ready, out_valid, out_quad, out_dst, out_data, credit_err, drop_cnt
  );

  modport slave (
    input  in_valid, in_dst, in_data, credit_ret,
    output in_ready, out_valid, out_quad, out_dst, out_data, credit_err, drop_cnt
  );
endinterface

// File: rtl/quadrant_dispatch.sv
// Injection dispatch: maps dst id to quadrant, buffers in an in-order FIFO, releases under per-quadrant credits.
// Optional macro QDISP_BAD_DST_DROP_EN drops accepted packets with dst > 19 and counts them in drop_cnt.
module quadrant_dispatch #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  quadrant_dispatch_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W = 4;
  localparam int unsigned NQ    = 4;

  typedef struct packed {
    logic [1:0]        quad;
    logic [4:0]        dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [CRD_W-1:0]   credit     [NQ];
  logic [CRD_W-1:0]   credit_nxt [NQ];
  entry_t             head;
  entry_t             wr_entry;
  logic               accept;
  logic               push;
  logic               head_ok;
  logic               err_set;

  // Node-to-quadrant table shared with the mesh routers.
  function automatic logic [1:0] quad_of(input logic [4:0] dst);
    case (dst)
      5'd0,  5'd1,  5'd4,  5'd5:                 quad_of = 2'b01;
      5'd2,  5'd3,  5'd6,  5'd7:                 quad_of = 2'b10;
      5'd8,  5'd9,  5'd12, 5'd13, 5'd16, 5'd17: quad_of = 2'b00;
      5'd10, 5'd11, 5'd14, 5'd15, 5'd18, 5'd19: quad_of = 2'b11;
      default:                                   quad_of = 2'b10;
    endcase
  endfunction

  // Handshake, head eligibility and FIFO occupancy.
  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    push     = accept;
    head     = mem[rd_ptr];
    head_ok  = (count != '0) && (credit[head.quad] != '0);
    wr_entry = '{quad: quad_of(bus.in_dst), dst: bus.in_dst, data: bus.in_data};
`ifdef QDISP_BAD_DST_DROP_EN
    if (bus.in_dst > 5'd19) begin
      push = 1'b0;
    end
`endif
    count_nxt = count + CNT_W'(push) - CNT_W'(head_ok);
  end

  // Credit bookkeeping: a return and a dispatch on the same quadrant cancel out.
  always_comb begin
    err_set = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      credit_nxt[q] = credit[q];
      if (bus.credit_ret[q] && !(head_ok && head.quad == 2'(q))) begin
        if (credit[q] == CRD_W'(CREDITS)) begin
          err_set = 1'b1;
        end else begin
          credit_nxt[q] = credit[q] + CRD_W'(1);
        end
      end else if (!bus.credit_ret[q] && head_ok && head.quad == 2'(q)) begin
        credit_nxt[q] = credit[q] - CRD_W'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_quad   <= '0;
      bus.out_dst    <= '0;
      bus.out_data   <= '0;
      bus.credit_err <= 1'b0;
      for (int q = 0; q < NQ; q++) begin
        credit[q] <= CRD_W'(CREDITS);
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (head_ok) begin
        rd_ptr       <= rd_ptr + PTR_W'(1);
        bus.out_quad <= head.quad;
        bus.out_dst  <= head.dst;
        bus.out_data <= head.data;
      end
      count          <= count_nxt;
      bus.in_ready   <= (count_nxt != CNT_W'(DEPTH));
      bus.out_valid  <= head_ok;
      bus.credit_err <= bus.credit_err | err_set;
      for (int q = 0; q < NQ; q++) begin
        credit[q] <= credit_nxt[q];
      end
    end
  end

`ifdef QDISP_BAD_DST_DROP_EN
  // Saturating count of accepted-but-discarded packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.drop_cnt <= '0;
    end else if (accept && !push && bus.drop_cnt != 8'hFF) begin
      bus.drop_cnt <= bus.drop_cnt + 8'd1;
    end
  end
`else
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_quadrant_dispatch.sv
// Self-checking bench for quadrant_dispatch: directed steps plus random traffic against a queue-based model.
module tb_quadrant_dispatch;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;
`ifdef QDISP_BAD_DST_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef struct {
    int          quad;
    int          dst;
    logic [31:0] data;
  } pkt_t;

  // Quadrant of node ids 0..19; anything above maps to 2.
  int qtab [20] = '{1, 1, 2, 2, 1, 1, 2, 2, 0, 0, 3, 3, 0, 0, 3, 3, 0, 0, 3, 3};

  bit clk = 1'b0;
  bit rst = 1'b1;
  always #5 clk = ~clk;

  quadrant_dispatch_if #(.DATA_W(DATA_W)) bus ();

  quadrant_dispatch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pkt_t        mq [$];
  int          cred [4];
  bit          m_ready;
  bit          m_err;
  int          m_drop;
  bit          e_valid;
  int          e_quad;
  int          e_dst;
  logic [31:0] e_data;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out_valid",  64'(bus.out_valid),  64'(e_valid));
    check("out_quad",   64'(bus.out_quad),   64'(e_quad));
    check("out_dst",    64'(bus.out_dst),    64'(e_dst));
    check("out_data",   64'(bus.out_data),   64'(e_data));
    check("in_ready",   64'(bus.in_ready),   64'(m_ready));
    check("credit_err", 64'(bus.credit_err), 64'(m_err));
    check("drop_cnt",   64'(bus.drop_cnt),   64'(m_drop));
  endtask

  task automatic model_reset();
    mq.delete();
    for (int q = 0; q < 4; q++) cred[q] = CREDITS;
    m_ready = 1'b1;
    m_err   = 1'b0;
    m_drop  = 0;
    e_valid = 1'b0;
    e_quad  = 0;
    e_dst   = 0;
    e_data  = '0;
  endtask

  task automatic model_edge(input bit v, input int d, input logic [31:0] dat, input logic [3:0] ret);
    bit   acc;
    bit   disp;
    int   hq;
    pkt_t p;
    acc  = v && m_ready;
    disp = (mq.size() != 0) && (cred[mq[0].quad] != 0);
    hq   = -1;
    e_valid = disp;
    if (disp) begin
      p      = mq.pop_front();
      hq     = p.quad;
      e_quad = p.quad;
      e_dst  = p.dst;
      e_data = p.data;
    end
    for (int q = 0; q < 4; q++) begin
      if (ret[q] && hq != q) begin
        if (cred[q] == CREDITS) m_err = 1'b1;
        else cred[q]++;
      end else if (!ret[q] && hq == q) begin
        cred[q]--;
      end
    end
    if (acc) begin
      if (DROP_EN && d > 19) begin
        if (m_drop < 255) m_drop++;
      end else begin
        p.quad = (d > 19) ? 2 : qtab[d];
        p.dst  = d;
        p.data = dat;
        mq.push_back(p);
      end
    end
    m_ready = (mq.size() != DEPTH);
  endtask

  task automatic step(input bit v, input int d, input logic [31:0] dat, input logic [3:0] ret);
    bus.in_valid   = v;
    bus.in_dst     = 5'(d);
    bus.in_data    = dat;
    bus.credit_ret = ret;
    @(posedge clk);
    model_edge(v, d, dat, ret);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, '0, 4'b0000);
  endtask

  // Offers one packet until the model says it was taken; bounded.
  task automatic send(input int d, input logic [31:0] dat);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      done = m_ready;
      step(1'b1, d, dat, 4'b0000);
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected=accepted", d);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_dst     = '0;
    bus.in_data    = '0;
    bus.credit_ret = '0;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_dst     = '0;
    bus.in_data    = '0;
    bus.credit_ret = '0;
    model_reset();

    // Reset state and single packet latency.
    do_reset();
    send(9, 32'hA5);
    idle(3);

    // Exhaust quadrant 2, fifth packet waits for a return.
    for (int i = 0; i < 5; i++) send(2, 32'h200 + 32'(i));
    idle(6);
    step(1'b0, 0, '0, 4'b0100);
    idle(3);

    // No bypass: head on an exhausted quadrant blocks a dispatchable one; fill to full.
    for (int i = 0; i < 4; i++) send(0, 32'h100 + 32'(i));
    idle(4);
    send(0, 32'h1FF);
    for (int i = 0; i < 3; i++) send(10, 32'h300 + 32'(i));
    idle(3);
    step(1'b1, 11, 32'hDEAD, 4'b0000);
    step(1'b0, 0, '0, 4'b0010);
    idle(6);

    // Reset with packets stuck behind exhausted quadrant 2.
    for (int i = 0; i < 3; i++) send(3, 32'h400 + 32'(i));
    idle(2);
    do_reset();
    idle(6);

    // Dispatch on q3 coincident with a return, then a return at full credit.
    send(18, 32'h1818);
    step(1'b0, 0, '0, 4'b1000);
    idle(2);
    step(1'b0, 0, '0, 4'b1000);
    idle(2);

    // Out-of-range destination.
    send(25, 32'h2525);
    idle(3);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) do_reset();
      else step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), $urandom,
                4'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
